// File: rtl/regcheck_pkg.sv
// Shared types and widths for the register-file consistency scheduler.
package regcheck_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        TRACK  = 2'd2,
        ROTATE = 2'd3
    } state_t;

    // Step to the next tracked register, wrapping from the last back to the first.
    function automatic logic [REG_ADDR_W-1:0] next_reg(
        input logic [REG_ADDR_W-1:0] cur,
        input logic [REG_ADDR_W-1:0] first,
        input logic [REG_ADDR_W-1:0] last
    );
        if (cur == last) begin
            return first;
        end
        return cur + REG_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/regcheck_shadow.sv
// Shadow copy of the register under check, its valid flag and the XOR comparator.
module regcheck_shadow
    import regcheck_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            invalidate,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic            valid,
    output logic [XLEN-1:0] diff
);

    logic [XLEN-1:0] shadow;

    // Invalidation beats a load so a rotation never leaves stale data marked valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow <= '0;
            valid  <= 1'b0;
        end else if (invalidate) begin
            valid  <= 1'b0;
        end else if (load) begin
            shadow <= wdata;
            valid  <= 1'b1;
        end
    end

    // Compare always sees the pre-load shadow, so read-and-write retirements check the old value.
    assign diff = shadow ^ rdata;

endmodule

// File: rtl/regcheck_scheduler.sv
// Rotating register-file checker driven by the RVFI retirement stream.
module regcheck_scheduler
    import regcheck_pkg::*;
#(
    parameter int DWELL     = 16,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  rvfi_valid,
    input  logic [REG_ADDR_W-1:0] rvfi_rd_addr,
    input  logic [REG_ADDR_W-1:0] rvfi_rs1_addr,
    input  logic [REG_ADDR_W-1:0] rvfi_rs2_addr,
    input  logic [XLEN-1:0]       rvfi_rd_wdata,
    input  logic [XLEN-1:0]       rvfi_rs1_rdata,
    input  logic [XLEN-1:0]       rvfi_rs2_rdata,
    output logic [REG_ADDR_W-1:0] cur_reg,
    output logic [1:0]            state,
    output logic                  check_fire,
    output logic [XLEN-1:0]       mismatch,
    output logic                  error,
    output logic [REG_ADDR_W-1:0] error_reg,
    output logic [15:0]           checks_done
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [REG_ADDR_W-1:0] FIRST = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST  = REG_ADDR_W'(LAST_REG);

    state_t                fsm_state, fsm_next;
    logic [REG_ADDR_W-1:0] cur_reg_next;
    logic [CNT_W-1:0]      dwell_count, dwell_next, dwell_inc;
    logic                  dwell_hit;
    logic                  shadow_load, shadow_invalidate, shadow_valid;
    logic                  do_compare;
    logic [XLEN-1:0]       read_data, diff;

    assign dwell_inc = dwell_count + CNT_W'(1);
    assign dwell_hit = (dwell_inc == CNT_W'(DWELL));
    assign read_data = (rvfi_rs1_addr == cur_reg) ? rvfi_rs1_rdata : rvfi_rs2_rdata;

    regcheck_shadow u_shadow (
        .clk        (clk),
        .rst        (rst),
        .load       (shadow_load),
        .invalidate (shadow_invalidate),
        .wdata      (rvfi_rd_wdata),
        .rdata      (read_data),
        .valid      (shadow_valid),
        .diff       (diff)
    );

    // Next-state, dwell counting and shadow control; disabling overrides everything.
    always_comb begin
        fsm_next          = fsm_state;
        cur_reg_next      = cur_reg;
        dwell_next        = dwell_count;
        shadow_load       = 1'b0;
        shadow_invalidate = 1'b0;
        do_compare        = 1'b0;
        if (!enable) begin
            fsm_next          = IDLE;
            shadow_invalidate = 1'b1;
        end else begin
            case (fsm_state)
                IDLE: fsm_next = ARM;
                ARM: begin
                    if (rvfi_valid) begin
                        if (dwell_hit) begin
                            fsm_next   = ROTATE;
                            dwell_next = '0;
                        end else begin
                            dwell_next = dwell_inc;
                            if (rvfi_rd_addr == cur_reg) begin
                                shadow_load = 1'b1;
                                fsm_next    = TRACK;
                            end
                        end
                    end
                end
                TRACK: begin
                    if (rvfi_valid) begin
                        do_compare  = shadow_valid &&
                                      ((rvfi_rs1_addr == cur_reg) || (rvfi_rs2_addr == cur_reg));
                        shadow_load = (rvfi_rd_addr == cur_reg);
                        if (dwell_hit) begin
                            fsm_next   = ROTATE;
                            dwell_next = '0;
                        end else begin
                            dwell_next = dwell_inc;
                        end
                    end
                end
                ROTATE: begin
                    cur_reg_next      = next_reg(cur_reg, FIRST, LAST);
                    shadow_invalidate = 1'b1;
                    fsm_next          = ARM;
                end
                default: fsm_next = IDLE;
            endcase
        end
    end

    // State, counters and the registered compare result with sticky error capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_state   <= IDLE;
            cur_reg     <= FIRST;
            dwell_count <= '0;
            check_fire  <= 1'b0;
            mismatch    <= '0;
            error       <= 1'b0;
            error_reg   <= '0;
            checks_done <= '0;
        end else begin
            fsm_state   <= fsm_next;
            cur_reg     <= cur_reg_next;
            dwell_count <= dwell_next;
            check_fire  <= do_compare;
            if (do_compare) begin
                mismatch <= diff;
                if (checks_done != 16'hFFFF) begin
                    checks_done <= checks_done + 16'd1;
                end
                if (diff != '0) begin
                    error <= 1'b1;
                    if (!error) begin
                        error_reg <= cur_reg;
                    end
                end
            end
        end
    end

    assign state = fsm_state;

endmodule

// File: tb/tb_regcheck_scheduler.sv
// Directed bench for regcheck_scheduler with DWELL=4 over registers x1..x31.
module tb_regcheck_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        rvfi_valid;
    logic [4:0]  rvfi_rd_addr, rvfi_rs1_addr, rvfi_rs2_addr;
    logic [31:0] rvfi_rd_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
    logic [4:0]  cur_reg;
    logic [1:0]  state;
    logic        check_fire;
    logic [31:0] mismatch;
    logic        error;
    logic [4:0]  error_reg;
    logic [15:0] checks_done;

    int passed_count = 0;
    int total_count  = 0;
    int fail_count   = 0;

    regcheck_scheduler #(.DWELL(4), .FIRST_REG(1), .LAST_REG(31)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .rvfi_valid     (rvfi_valid),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rs1_addr  (rvfi_rs1_addr),
        .rvfi_rs2_addr  (rvfi_rs2_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_rs1_rdata (rvfi_rs1_rdata),
        .rvfi_rs2_rdata (rvfi_rs2_rdata),
        .cur_reg        (cur_reg),
        .state          (state),
        .check_fire     (check_fire),
        .mismatch       (mismatch),
        .error          (error),
        .error_reg      (error_reg),
        .checks_done    (checks_done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // One cycle carrying a single retirement; outputs are sampled 1 unit after the edge.
    task automatic apply_stimulus(input logic [4:0] rd, input logic [31:0] wd,
                                  input logic [4:0] rs1, input logic [31:0] d1,
                                  input logic [4:0] rs2, input logic [31:0] d2);
        rvfi_valid     = 1'b1;
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = wd;
        rvfi_rs1_addr  = rs1;
        rvfi_rs1_rdata = d1;
        rvfi_rs2_addr  = rs2;
        rvfi_rs2_rdata = d2;
        @(posedge clk);
        #1;
        rvfi_valid = 1'b0;
    endtask

    // One cycle with no retirement; junk on the address buses must be ignored.
    task automatic idle_cycle();
        rvfi_valid    = 1'b0;
        rvfi_rd_addr  = cur_reg;
        rvfi_rs1_addr = cur_reg;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total_count++;
        assert (observed === expected) begin
            passed_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        rvfi_valid = 1'b0;
        rvfi_rd_addr = '0; rvfi_rs1_addr = '0; rvfi_rs2_addr = '0;
        rvfi_rd_wdata = '0; rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 32'(state), 32'd0);
        check_output("reset_cur_reg", 32'(cur_reg), 32'd1);
        check_output("reset_fire", 32'(check_fire), 32'd0);
        check_output("reset_mismatch", mismatch, 32'd0);
        check_output("reset_error", 32'(error), 32'd0);
        check_output("reset_checks", 32'(checks_done), 32'd0);

        rst = 1'b1;
        enable = 1'b1;
        idle_cycle();
        check_output("idle_to_arm", 32'(state), 32'd1);

        // x1 written then read back clean via rs1
        apply_stimulus(5'd1, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 32'h0);
        check_output("arm_to_track", 32'(state), 32'd2);
        check_output("no_fire_on_load", 32'(check_fire), 32'd0);
        apply_stimulus(5'd0, 32'h0, 5'd1, 32'hDEADBEEF, 5'd0, 32'h0);
        check_output("clean_fire", 32'(check_fire), 32'd1);
        check_output("clean_mismatch", mismatch, 32'd0);
        check_output("clean_error", 32'(error), 32'd0);
        check_output("clean_checks", 32'(checks_done), 32'd1);

        // Corrupted read via rs2
        apply_stimulus(5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'hDEADBEEE);
        check_output("bad_mismatch", mismatch, 32'h00000001);
        check_output("bad_error", 32'(error), 32'd1);
        check_output("bad_error_reg", 32'(error_reg), 32'd1);
        idle_cycle();
        check_output("fire_pulse_ends", 32'(check_fire), 32'd0);
        check_output("mismatch_holds", mismatch, 32'h00000001);

        // Fourth retirement: clean compare that also triggers rotation
        apply_stimulus(5'd0, 32'h0, 5'd1, 32'hDEADBEEF, 5'd0, 32'h0);
        check_output("rotate_state", 32'(state), 32'd3);
        check_output("rotate_compare_fire", 32'(check_fire), 32'd1);
        check_output("later_clean_mismatch", mismatch, 32'd0);
        check_output("error_sticky", 32'(error), 32'd1);
        check_output("error_reg_sticky", 32'(error_reg), 32'd1);
        check_output("checks_three", 32'(checks_done), 32'd3);
        idle_cycle();
        check_output("after_rotate_state", 32'(state), 32'd1);
        check_output("after_rotate_reg", 32'(cur_reg), 32'd2);

        // ARM on x2 with no writes: reads are ignored, dwell still rotates
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(5'd5, 32'h1, 5'd2, 32'h123, 5'd0, 32'h0);
        end
        check_output("arm_no_fire", 32'(check_fire), 32'd0);
        check_output("arm_still", 32'(state), 32'd1);
        apply_stimulus(5'd5, 32'h1, 5'd2, 32'h123, 5'd0, 32'h0);
        check_output("arm_rotate", 32'(state), 32'd3);
        idle_cycle();
        check_output("arm_rotate_reg", 32'(cur_reg), 32'd3);
        check_output("arm_rotate_checks", 32'(checks_done), 32'd3);

        // x3: load-and-read in ARM is not checked
        apply_stimulus(5'd3, 32'h000000A5, 5'd3, 32'h000000FF, 5'd0, 32'h0);
        check_output("arm_load_state", 32'(state), 32'd2);
        check_output("arm_load_no_fire", 32'(check_fire), 32'd0);

        // Drop enable in TRACK, re-enable, read without a fresh write
        enable = 1'b0;
        idle_cycle();
        check_output("disable_idle", 32'(state), 32'd0);
        check_output("disable_reg_held", 32'(cur_reg), 32'd3);
        enable = 1'b1;
        idle_cycle();
        check_output("reenable_arm", 32'(state), 32'd1);
        apply_stimulus(5'd0, 32'h0, 5'd3, 32'h0, 5'd0, 32'h0);
        check_output("reenable_no_fire", 32'(check_fire), 32'd0);
        check_output("reenable_no_check", 32'(checks_done), 32'd3);
        apply_stimulus(5'd3, 32'h10, 5'd0, 32'h0, 5'd0, 32'h0);
        check_output("reenable_track", 32'(state), 32'd2);
        apply_stimulus(5'd0, 32'h0, 5'd3, 32'h10, 5'd0, 32'h0);
        check_output("held_dwell_rotate", 32'(state), 32'd3);
        check_output("held_dwell_checks", 32'(checks_done), 32'd4);
        idle_cycle();
        check_output("reg_four", 32'(cur_reg), 32'd4);

        // Walk up to x31
        for (int r = 0; r < 27; r++) begin
            for (int k = 0; k < 4; k++) begin
                apply_stimulus(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
            end
            idle_cycle();
        end
        check_output("reached_31", 32'(cur_reg), 32'd31);

        // x31: read+write retirement compares against the old shadow value
        apply_stimulus(5'd31, 32'd3, 5'd0, 32'h0, 5'd0, 32'h0);
        apply_stimulus(5'd31, 32'd5, 5'd31, 32'd3, 5'd0, 32'h0);
        check_output("rw_fire", 32'(check_fire), 32'd1);
        check_output("rw_old_shadow", mismatch, 32'd0);
        apply_stimulus(5'd0, 32'h0, 5'd31, 32'd5, 5'd0, 32'h0);
        check_output("rw_new_shadow", mismatch, 32'd0);
        check_output("rw_checks", 32'(checks_done), 32'd6);
        apply_stimulus(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        idle_cycle();
        check_output("wrap_to_1", 32'(cur_reg), 32'd1);

        // Rotate once more to x2, enter TRACK, then reset during a failing compare
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
        end
        idle_cycle();
        apply_stimulus(5'd2, 32'd7, 5'd0, 32'h0, 5'd0, 32'h0);
        check_output("pre_reset_track", 32'(state), 32'd2);
        check_output("pre_reset_reg", 32'(cur_reg), 32'd2);
        rst = 1'b0;
        apply_stimulus(5'd0, 32'h0, 5'd2, 32'd6, 5'd0, 32'h0);
        check_output("mid_reset_state", 32'(state), 32'd0);
        check_output("mid_reset_reg", 32'(cur_reg), 32'd1);
        check_output("mid_reset_fire", 32'(check_fire), 32'd0);
        check_output("mid_reset_mismatch", mismatch, 32'd0);
        check_output("mid_reset_error", 32'(error), 32'd0);
        check_output("mid_reset_error_reg", 32'(error_reg), 32'd0);
        check_output("mid_reset_checks", 32'(checks_done), 32'd0);
        rst = 1'b1;
        idle_cycle();
        check_output("post_reset_arm", 32'(state), 32'd1);

        $display("%0d/%0d checks passed", passed_count, total_count);
        $finish;
    end

endmodule
